// File: rtl/pipelined_addsub.sv
// pipelined_addsub: WIDTH-bit add/subtract with the carry chain cut into STAGES registered
// segments and valid/ready flow control. Define ADDER_SAT_EN to clamp overflowing results.
module pipelined_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);
  localparam int CW = WIDTH / STAGES;

  if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_param_check
    $error("pipelined_addsub: STAGES must divide WIDTH and lie in 1..WIDTH");
  end

  logic             en;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  // Subtract is a + ~b + 1; cin only matters in add mode.
  assign b_eff    = sub ? ~b : b;
  assign c0       = sub | cin;
  assign en       = out_ready | ~out_valid;
  assign in_ready = en;

  // Stage k adds chunk k; finished low chunks and untouched high operand chunks ride along.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LOW = (k + 1) * CW;

    logic [CW-1:0]  op_a;
    logic [CW-1:0]  op_b;
    logic           c_in;
    logic           v_in;
    logic [CW:0]    sum;
    logic [LOW-1:0] lo_d;
    logic [LOW-1:0] res_d;
    logic [LOW-1:0] lo_q;
    logic           c_q;
    logic           v_q;

    assign sum = {1'b0, op_a} + {1'b0, op_b} + {{CW{1'b0}}, c_in};

    if (k == 0) begin : g_src
      assign op_a = a[CW-1:0];
      assign op_b = b_eff[CW-1:0];
      assign c_in = c0;
      assign v_in = in_valid;
      assign lo_d = sum[CW-1:0];
    end else begin : g_src
      assign op_a = g_stage[k-1].g_fwd.a_hi_q[CW-1:0];
      assign op_b = g_stage[k-1].g_fwd.b_hi_q[CW-1:0];
      assign c_in = g_stage[k-1].c_q;
      assign v_in = g_stage[k-1].v_q;
      assign lo_d = {sum[CW-1:0], g_stage[k-1].lo_q};
    end

    if (k < STAGES - 1) begin : g_fwd
      localparam int HW = WIDTH - LOW;

      logic [HW-1:0] a_hi_d;
      logic [HW-1:0] b_hi_d;
      logic [HW-1:0] a_hi_q;
      logic [HW-1:0] b_hi_q;

      if (k == 0) begin : g_hi_src
        assign a_hi_d = a[WIDTH-1:CW];
        assign b_hi_d = b_eff[WIDTH-1:CW];
      end else begin : g_hi_src
        assign a_hi_d = g_stage[k-1].g_fwd.a_hi_q[HW+CW-1:CW];
        assign b_hi_d = g_stage[k-1].g_fwd.b_hi_q[HW+CW-1:CW];
      end

      assign res_d = lo_d;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_hi_q <= '0;
          b_hi_q <= '0;
        end else if (en) begin
          a_hi_q <= a_hi_d;
          b_hi_q <= b_hi_d;
        end
      end
    end else begin : g_last
      logic ovf_d;
      logic ovf_q;

      // The MSBs of a and b_eff arrive here as the top bits of the final chunk.
      assign ovf_d = (op_a[CW-1] == op_b[CW-1]) & (sum[CW-1] != op_a[CW-1]);

`ifdef ADDER_SAT_EN
      assign res_d = !ovf_d      ? lo_d :
                     op_a[CW-1]  ? {1'b1, {(WIDTH-1){1'b0}}} :
                                   {1'b0, {(WIDTH-1){1'b1}}};
`else
      assign res_d = lo_d;
`endif

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (en) begin
          ovf_q <= ovf_d;
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        lo_q <= '0;
        c_q  <= 1'b0;
        v_q  <= 1'b0;
      end else if (en) begin
        lo_q <= res_d;
        c_q  <= sum[CW];
        v_q  <= v_in;
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].v_q;
  assign s         = g_stage[STAGES-1].lo_q;
  assign cout      = g_stage[STAGES-1].c_q;
  assign ovf       = g_stage[STAGES-1].g_last.ovf_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// tb_pipelined_addsub: directed vector table plus randomized valid/ready traffic checked
// against an arithmetic reference model for pipelined_addsub (WIDTH=32, STAGES=4).
module tb_pipelined_addsub;
  localparam int WIDTH  = 32;
  localparam int STAGES = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;

  pipelined_addsub #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] va;
    logic [31:0] vb;
    logic        vcin;
    logic        vsub;
    logic [31:0] exp_s;
    logic        exp_cout;
    logic        exp_ovf;
  } vec_t;

  typedef struct {
    logic [31:0] rs;
    logic        rc;
    logic        rv;
  } res_t;

  vec_t vecs[10];
  res_t pending[$];
  int   tests    = 0;
  int   failures = 0;
  int   emitted  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: exact signed/unsigned arithmetic, overflow = ideal result outside 32-bit range.
  function automatic res_t model(input logic [31:0] ma, input logic [31:0] mb,
                                 input logic mcin, input logic msub);
    res_t   r;
    longint sa;
    longint sb;
    longint ideal;
    sa = $signed(ma);
    sb = $signed(mb);
    if (msub) begin
      ideal = sa - sb;
      r.rs  = ma - mb;
      r.rc  = (ma >= mb);
    end else begin
      ideal = sa + sb + longint'(mcin);
      {r.rc, r.rs} = {1'b0, ma} + {1'b0, mb} + {32'b0, mcin};
    end
    r.rv = (ideal > 64'sd2147483647) || (ideal < -64'sd2147483648);
`ifdef ADDER_SAT_EN
    if (r.rv) r.rs = ma[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clock of traffic: drive, check pre-edge outputs against the model queue, then clock.
  task automatic apply_stimulus(input logic iv, input logic [31:0] ia, input logic [31:0] ib,
                                input logic icin, input logic isub, input logic iordy,
                                output logic accepted);
    res_t head;
    in_valid  = iv;
    a         = ia;
    b         = ib;
    cin       = icin;
    sub       = isub;
    out_ready = iordy;
    #1;
    if (!out_valid) check("in_ready_idle", {31'b0, in_ready}, 32'd1);
    if (out_valid && !out_ready) check("in_ready_stall", {31'b0, in_ready}, 32'd0);
    if (out_valid) check_output();
    accepted = in_valid && in_ready;
    if (accepted) pending.push_back(model(ia, ib, icin, isub));
    if (out_valid && out_ready && pending.size() > 0) begin
      head = pending.pop_front();
      emitted++;
    end
    tick();
  endtask

  task automatic check_output();
    res_t head;
    if (pending.size() == 0) begin
      check("spurious_out_valid", {31'b0, out_valid}, 32'd0);
    end else begin
      head = pending[0];
      check("s", s, head.rs);
      check("cout", {31'b0, cout}, {31'b0, head.rc});
      check("ovf", {31'b0, ovf}, {31'b0, head.rv});
    end
  endtask

  initial begin
    logic        acc;
    int          lat;
    int          sent;
    int          base;
    int          mode;
    logic [31:0] ra;
    logic [31:0] rb;

    vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
`ifdef ADDER_SAT_EN
    vecs[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1};
    vecs[4] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h8000_0000, 1'b1, 1'b1};
    vecs[7] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h8000_0000, 1'b1, 1'b1};
`else
    vecs[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vecs[4] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
    vecs[7] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
`endif
    vecs[2] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vecs[3] = '{32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0};
    vecs[5] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[6] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    vecs[8] = '{32'h1234_5678, 32'h0F0F_0F0F, 1'b1, 1'b0, 32'h2143_6588, 1'b0, 1'b0};
    vecs[9] = '{32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0007, 1'b1, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b0;
    #3;
    check("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("reset_s", s, 32'd0);
    check("reset_cout", {31'b0, cout}, 32'd0);
    check("reset_ovf", {31'b0, ovf}, 32'd0);
    check("reset_in_ready", {31'b0, in_ready}, 32'd1);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_out_valid", {31'b0, out_valid}, 32'd0);
      check("idle_in_ready", {31'b0, in_ready}, 32'd1);
    end

    // Directed vectors one at a time, measuring latency from the accepting edge.
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; a = vecs[i].va; b = vecs[i].vb;
      cin = vecs[i].vcin; sub = vecs[i].vsub; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 10) begin
        tick();
        lat++;
      end
      check($sformatf("vec%0d_latency", i), lat, STAGES - 1);
      check($sformatf("vec%0d_s", i), s, vecs[i].exp_s);
      check($sformatf("vec%0d_cout", i), {31'b0, cout}, {31'b0, vecs[i].exp_cout});
      check($sformatf("vec%0d_ovf", i), {31'b0, ovf}, {31'b0, vecs[i].exp_ovf});
      tick();
      check($sformatf("vec%0d_drained", i), {31'b0, out_valid}, 32'd0);
    end

    // Eight back-to-back ops with out_ready low for three cycles mid-stream.
    base = emitted;
    sent = 0;
    for (int c = 0; c < 40 && (sent < 8 || pending.size() > 0); c++) begin
      ra = $urandom;
      rb = $urandom;
      apply_stimulus(sent < 8, ra, rb, 1'(c & 1), 1'(sent % 3 == 0),
                     !(c >= 3 && c <= 5), acc);
      if (acc) sent++;
    end
    check("burst_sent", sent, 8);
    check("burst_emitted", emitted - base, 8);

    // Random traffic with random backpressure and edge-biased operands.
    base = emitted;
    sent = 0;
    for (int c = 0; c < 300; c++) begin
      mode = $urandom_range(0, 5);
      ra = (mode == 0) ? 32'hFFFF_FFFF : (mode == 1) ? 32'h7FFF_FFFF : $urandom;
      rb = (mode == 0) ? 32'h0000_0001 : (mode == 2) ? 32'h8000_0000 : $urandom;
      apply_stimulus($urandom_range(0, 9) < 7, ra, rb, 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, acc);
      if (acc) sent++;
    end
    for (int c = 0; c < 30 && pending.size() > 0; c++)
      apply_stimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
    check("random_all_emitted", emitted - base, sent);
    check("random_queue_empty", pending.size(), 0);

    // Reset with ops in flight: outputs clear at once and nothing emerges afterwards.
    for (int i = 0; i < 3; i++)
      apply_stimulus(1'b1, 32'h100 + i, 32'h7, 1'b0, 1'b0, 1'b1, acc);
    apply_stimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, acc);
    check("pre_reset_out_valid", {31'b0, out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("async_reset_s", s, 32'd0);
    check("async_reset_cout", {31'b0, cout}, 32'd0);
    pending.delete();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      check("post_reset_quiet", {31'b0, out_valid}, 32'd0);
      apply_stimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "[TB] timeout");
  end

endmodule
